ldpc_enc_ctrl: RTL and testbench



---
 rtl/ldpc_enc_ctrl.sv | 169 ++++++++++++++++
 tb/tb_ldpc_enc_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_enc_ctrl.sv
// rtl/ldpc_enc_ctrl.sv - LDPC encoder main FSM: data phase, accumulator drain, parity phase, buffer handoff.
// Optional block counter output ostat_blocks is enabled by defining LDPC_ENC_CTRL_STAT_EN.
module ldpc_enc_ctrl #(
    parameter int pDATA_SIZE  = 8,
    parameter int pBLOCK_SIZE = 12,
    parameter int pADDR_W     = 8
) (
    input  logic               iclk,
    input  logic               ireset,
    input  logic               iclkena,
    input  logic               ibuf_full,
    output logic               obuf_rempty,
    input  logic               iobuf_empty,
    output logic               oobuf_wfull,
    output logic               oaddr_clear,
    output logic               oaddr_enable,
    output logic [pADDR_W-1:0] oaddr,
    output logic               opar_mode,
    output logic               oacc_sop,
    output logic               oacc_val,
    output logic               oacc_eop,
    input  logic               iacc_busy,
    output logic               osop,
    output logic               oval,
    output logic               oeop,
`ifdef LDPC_ENC_CTRL_STAT_EN
    output logic [15:0]        ostat_blocks,
`endif
    output logic               obusy
);

    typedef enum logic [2:0] {
        S_RESET    = 3'd0,
        S_WAIT     = 3'd1,
        S_DSTEP    = 3'd2,
        S_WAIT_ACC = 3'd3,
        S_PSTEP    = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    // done is raised one step early, so compare against limit-2
    localparam logic [pADDR_W-1:0] D_LAST2 = pADDR_W'(pDATA_SIZE - 2);
    localparam logic [pADDR_W-1:0] P_LAST2 = pADDR_W'(pBLOCK_SIZE - pDATA_SIZE - 2);

    state_t             state_q, state_d;
    logic [pADDR_W-1:0] cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               zero_q, zero_d;

    logic clear_q, clear_d, enable_q, enable_d, par_q, par_d, rel_q, rel_d, busy_q, busy_d;
    logic asop_q, asop_d, aval_q, aval_d, aeop_q, aeop_d;
    logic sop_q, sop_d, val_q, val_d, eop_q, eop_d;
    logic [pADDR_W-1:0] addr_q;

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            state_q  <= S_RESET;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            zero_q   <= 1'b0;
            clear_q  <= 1'b0;
            enable_q <= 1'b0;
            par_q    <= 1'b0;
            rel_q    <= 1'b0;
            busy_q   <= 1'b0;
            asop_q   <= 1'b0;
            aval_q   <= 1'b0;
            aeop_q   <= 1'b0;
            sop_q    <= 1'b0;
            val_q    <= 1'b0;
            eop_q    <= 1'b0;
            addr_q   <= '0;
        end else if (iclkena) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            zero_q   <= zero_d;
            clear_q  <= clear_d;
            enable_q <= enable_d;
            par_q    <= par_d;
            rel_q    <= rel_d;
            busy_q   <= busy_d;
            asop_q   <= asop_d;
            aval_q   <= aval_d;
            aeop_q   <= aeop_d;
            sop_q    <= sop_d;
            val_q    <= val_d;
            eop_q    <= eop_d;
            addr_q   <= cnt_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        zero_d  = zero_q;
        case (state_q)
            S_RESET:    state_d = S_WAIT;
            S_WAIT:     if (ibuf_full && iobuf_empty) state_d = S_DSTEP;
            S_DSTEP:    if (done_q) state_d = S_WAIT_ACC;
            S_WAIT_ACC: if (!iacc_busy) state_d = S_PSTEP;
            S_PSTEP:    if (done_q) state_d = S_DONE;
            S_DONE:     state_d = S_WAIT;
            default:    state_d = S_RESET;
        endcase

        case (state_q)
            S_WAIT, S_WAIT_ACC: begin
                cnt_d  = '0;
                done_d = 1'b0;
                zero_d = 1'b1;
            end
            S_DSTEP: begin
                cnt_d  = cnt_q + 1'b1;
                zero_d = 1'b0;
                done_d = (cnt_q == D_LAST2);
            end
            S_PSTEP: begin
                cnt_d  = cnt_q + 1'b1;
                zero_d = 1'b0;
                done_d = (cnt_q == P_LAST2);
            end
            default: ;
        endcase

        // Control outputs follow the next state; strobes follow the current state
        clear_d  = (state_d == S_WAIT) || (state_d == S_WAIT_ACC);
        enable_d = (state_d == S_DSTEP) || (state_d == S_PSTEP);
        par_d    = (state_d == S_WAIT_ACC) || (state_d == S_PSTEP);
        rel_d    = (state_d == S_DONE);
        busy_d   = (state_d != S_WAIT);
        aval_d   = (state_q == S_DSTEP);
        asop_d   = (state_q == S_DSTEP) && zero_q;
        aeop_d   = (state_q == S_DSTEP) && done_q;
        val_d    = (state_q == S_DSTEP) || (state_q == S_PSTEP);
        sop_d    = (state_q == S_DSTEP) && zero_q;
        eop_d    = (state_q == S_PSTEP) && done_q;
    end

    assign oaddr_clear  = clear_q;
    assign oaddr_enable = enable_q;
    assign opar_mode    = par_q;
    assign obuf_rempty  = rel_q;
    assign oobuf_wfull  = rel_q;
    assign obusy        = busy_q;
    assign oacc_sop     = asop_q;
    assign oacc_val     = aval_q;
    assign oacc_eop     = aeop_q;
    assign osop         = sop_q;
    assign oval         = val_q;
    assign oeop         = eop_q;
    assign oaddr        = addr_q;

`ifdef LDPC_ENC_CTRL_STAT_EN
    logic [15:0] stat_q;

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            stat_q <= '0;
        end else if (iclkena && (state_q == S_DONE) && (stat_q != 16'hFFFF)) begin
            stat_q <= stat_q + 16'd1;
        end
    end

    assign ostat_blocks = stat_q;
`endif

endmodule

// File: tb/tb_ldpc_enc_ctrl.sv
// tb/tb_ldpc_enc_ctrl.sv - directed bench for ldpc_enc_ctrl with 4 data / 6 codeword words per block.
module tb_ldpc_enc_ctrl;
    localparam int D  = 4;
    localparam int B  = 6;
    localparam int AW = 4;

    logic iclk = 1'b0;
    logic ireset = 1'b1;
    logic iclkena = 1'b1;
    logic ibuf_full = 1'b0;
    logic iobuf_empty = 1'b1;
    logic iacc_busy = 1'b0;
    logic obuf_rempty, oobuf_wfull, oaddr_clear, oaddr_enable, opar_mode;
    logic oacc_sop, oacc_val, oacc_eop, osop, oval, oeop, obusy;
    logic [AW-1:0] oaddr;
`ifdef LDPC_ENC_CTRL_STAT_EN
    logic [15:0] ostat_blocks;
`endif

    ldpc_enc_ctrl #(.pDATA_SIZE(D), .pBLOCK_SIZE(B), .pADDR_W(AW)) dut (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .ibuf_full(ibuf_full),
        .obuf_rempty(obuf_rempty), .iobuf_empty(iobuf_empty), .oobuf_wfull(oobuf_wfull),
        .oaddr_clear(oaddr_clear), .oaddr_enable(oaddr_enable), .oaddr(oaddr),
        .opar_mode(opar_mode), .oacc_sop(oacc_sop), .oacc_val(oacc_val), .oacc_eop(oacc_eop),
        .iacc_busy(iacc_busy), .osop(osop), .oval(oval), .oeop(oeop),
`ifdef LDPC_ENC_CTRL_STAT_EN
        .ostat_blocks(ostat_blocks),
`endif
        .obusy(obusy)
    );

    always #5 iclk = ~iclk;

    // clear, enable, par, rempty, wfull, busy | acc_sop, acc_val, acc_eop, sop, val, eop
    wire [11:0] flags = {oaddr_clear, oaddr_enable, opar_mode, obuf_rempty, oobuf_wfull, obusy,
                         oacc_sop, oacc_val, oacc_eop, osop, oval, oeop};

    int total = 0;
    int passed = 0;
    int failed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge iclk);
        #1;
    endtask

    task automatic run_to_done(input string tag, output int na, output int nv, output int nr);
        na = 0; nv = 0; nr = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            na += int'(oacc_val);
            nv += int'(oval);
            nr += int'(obuf_rempty);
            if (oobuf_wfull) break;
        end
        chk({tag, "_wfull_seen"}, 32'(oobuf_wfull), 32'd1);
        step();
    endtask

    logic [11:0] exp_f [11];
    logic [3:0]  exp_a [11];

    initial begin
        int na, nv, nr, ns, ne, asum, hold_err;
        logic [15:0] prev;

        exp_f = '{12'b100000_000000, 12'b010001_000000, 12'b010001_110110, 12'b010001_010010,
                  12'b010001_010010, 12'b101001_011010, 12'b011001_000000, 12'b011001_000010,
                  12'b000111_000011, 12'b100000_000000, 12'b100000_000000};
        exp_a = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1, 4'd2, 4'd2};

        // reset state
        step();
        chk("reset_flags", 32'(flags), 32'd0);
        chk("reset_addr", 32'(oaddr), 32'd0);

        // test 1: nominal block, ibuf_full dropped mid-block
        ireset = 1'b0;
        ibuf_full = 1'b1;
        for (int i = 0; i < 11; i++) begin
            step();
            if (i == 1) ibuf_full = 1'b0;
            chk($sformatf("t1_flags_e%0d", i + 1), 32'(flags), 32'(exp_f[i]));
            chk($sformatf("t1_addr_e%0d", i + 1), 32'(oaddr), 32'(exp_a[i]));
        end

        // test 2: output buffer not ready holds WAIT
        ibuf_full = 1'b1;
        iobuf_empty = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("t2_wait_%0d", i), 32'(flags), 32'b100000_000000);
        end
        iobuf_empty = 1'b1;
        step();
        chk("t2_dstep_entry", 32'(flags), 32'b010001_000000);
        ibuf_full = 1'b0;
        run_to_done("t2", na, nv, nr);
        chk("t2_acc_cnt", 32'(na), 32'd4);
        chk("t2_val_cnt", 32'(nv), 32'd6);
        chk("t2_rel_cnt", 32'(nr), 32'd1);

        // test 3: accumulator busy stalls the parity phase
        iacc_busy = 1'b1;
        ibuf_full = 1'b1;
        step();
        ibuf_full = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (oacc_eop) break;
        end
        chk("t3_eop_seen", 32'(oacc_eop), 32'd1);
        chk("t3_par_at_eop", 32'(opar_mode), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("t3_gap_%0d", i), 32'({oval, opar_mode, oaddr_enable}), 32'b010);
        end
        iacc_busy = 1'b0;
        step();
        chk("t3_pstep_entry", 32'({oval, oaddr_enable}), 32'b01);
        step();
        chk("t3_first_par", 32'({oval, oaddr}), 32'({1'b1, 4'd0}));
        run_to_done("t3", na, nv, nr);
        chk("t3_val_rest", 32'(nv), 32'd1);
        chk("t3_rel_cnt", 32'(nr), 32'd1);

        // test 4: clock enable toggling every cycle
        ibuf_full = 1'b1;
        na = 0; nv = 0; nr = 0; ns = 0; ne = 0; asum = 0; hold_err = 0;
        prev = {flags, oaddr};
        for (int i = 0; i < 24; i++) begin
            iclkena = (i % 2 == 0);
            step();
            if (iclkena) begin
                ibuf_full = 1'b0;
                na += int'(oacc_val);
                nv += int'(oval);
                nr += int'(obuf_rempty);
                ns += int'(osop);
                ne += int'(oeop);
                if (oval) asum += int'(oaddr);
            end else if ({flags, oaddr} !== prev) begin
                hold_err++;
            end
            prev = {flags, oaddr};
        end
        iclkena = 1'b1;
        chk("t4_hold", 32'(hold_err), 32'd0);
        chk("t4_acc_cnt", 32'(na), 32'd4);
        chk("t4_val_cnt", 32'(nv), 32'd6);
        chk("t4_sop_cnt", 32'(ns), 32'd1);
        chk("t4_eop_cnt", 32'(ne), 32'd1);
        chk("t4_rel_cnt", 32'(nr), 32'd1);
        chk("t4_addr_sum", 32'(asum), 32'd7);

        // test 5: async reset on the 3rd DSTEP cycle
        ibuf_full = 1'b1;
        step();
        ibuf_full = 1'b0;
        step();
        step();
        #2 ireset = 1'b1;
        #1;
        chk("t5_async_flags", 32'(flags), 32'd0);
        chk("t5_async_addr", 32'(oaddr), 32'd0);
        step();
        chk("t5_held_flags", 32'(flags), 32'd0);
        ireset = 1'b0;
        step();
        chk("t5_wait_entry", 32'(flags), 32'b100000_000000);
        nr = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            nr += int'(obuf_rempty);
        end
        chk("t5_no_release", 32'(nr), 32'd0);
        chk("t5_idle", 32'(flags), 32'b100000_000000);
        ibuf_full = 1'b1;
        step();
        ibuf_full = 1'b0;
        run_to_done("t5", na, nv, nr);
        chk("t5_acc_cnt", 32'(na), 32'd4);
        chk("t5_val_cnt", 32'(nv), 32'd6);
        chk("t5_rel_cnt", 32'(nr), 32'd1);

`ifdef LDPC_ENC_CTRL_STAT_EN
        // test 6: block counter and saturation
        ireset = 1'b1;
        step();
        ireset = 1'b0;
        chk("t6_stat_reset", 32'(ostat_blocks), 32'd0);
        ibuf_full = 1'b1;
        nr = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            nr += int'(oobuf_wfull);
            if (nr == 3) break;
        end
        ibuf_full = 1'b0;
        step();
        step();
        chk("t6_blocks_seen", 32'(nr), 32'd3);
        chk("t6_stat_3", 32'(ostat_blocks), 32'd3);
        force dut.stat_q = 16'hFFFE;
        step();
        release dut.stat_q;
        chk("t6_preload", 32'(ostat_blocks), 32'hFFFE);
        ibuf_full = 1'b1;
        nr = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            nr += int'(oobuf_wfull);
            if (nr == 2) break;
        end
        ibuf_full = 1'b0;
        step();
        step();
        chk("t6_stat_sat", 32'(ostat_blocks), 32'hFFFF);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
